// File: rtl/cnt_arb_pkg.sv
// cnt_arb_pkg: shared FSM states, counter command codes and default width for cnt_arbiter
package cnt_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   localparam logic CMD_LOAD = 1'b0;
   localparam logic CMD_INC  = 1'b1;
   localparam int   DW_DEF   = 8;
endpackage

// File: rtl/cnt_arbiter_if.sv
// cnt_arbiter_if: requester and counter bus of cnt_arbiter
// Signals: req/req_cmd/req_data/req_addr (requests), gnt (grant pulse),
// rsp_valid/rsp_id/rsp_data (response), cmd/data/addr (counter drive), dout (counter value).
// slave = arbiter side, master = requester/counter environment side.
interface cnt_arbiter_if
   import cnt_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = DW_DEF
);
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_cmd;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ*DW-1:0] req_addr;
   logic [NREQ-1:0]    gnt;
   logic               rsp_valid;
   logic [IW-1:0]      rsp_id;
   logic [DW-1:0]      rsp_data;
   logic               cmd;
   logic [DW-1:0]      data;
   logic [DW-1:0]      addr;
   logic [DW-1:0]      dout;
   modport slave (
      input  req, req_cmd, req_data, req_addr, dout,
      output gnt, rsp_valid, rsp_id, rsp_data, cmd, data, addr
   );
   modport master (
      output req, req_cmd, req_data, req_addr, dout,
      input  gnt, rsp_valid, rsp_id, rsp_data, cmd, data, addr
   );
endinterface

// File: rtl/cnt_arbiter_rr_pick.sv
// rr_pick: combinational winner select; round-robin from ptr_i, or lowest-index
// priority when CNT_ARB_FIXED_PRIO_EN is defined (ptr_i then does not exist).
// Ports: req_i (requests), ptr_i (search start), onehot_o (winner one-hot),
// idx_o (winner index), any_o (some request active).
module rr_pick #(
   parameter int NREQ = 4,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
`ifndef CNT_ARB_FIXED_PRIO_EN
   input  logic [IW-1:0]   ptr_i,
`endif
   output logic [NREQ-1:0] onehot_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);
   // Scan from the far end back toward the start so the first match in search order is kept last.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
         automatic int i = k;
`else
         automatic int i = (int'(ptr_i) + k) % NREQ;
`endif
         if (req_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            idx_o       = IW'(i);
         end
      end
   end
   assign any_o = |req_i;
endmodule

// File: rtl/cnt_arbiter.sv
// cnt_arbiter: shares one load/increment counter among NREQ requesters, one op per 3 cycles.
// Ports: clk, rst (sync, active-high), bus (cnt_arbiter_if.slave: requests in, grant,
// response and counter drive out, counter value dout in).
// CNT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module cnt_arbiter
   import cnt_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = DW_DEF,
   localparam int IW  = $clog2(NREQ)
) (
   input logic          clk,
   input logic          rst,
   cnt_arbiter_if.slave bus
);
   state_t          state_q, state_d;
   logic [IW-1:0]   id_q, id_d;
   logic            cmd_q, cmd_d;
   logic [DW-1:0]   data_q, data_d;
   logic [DW-1:0]   addr_q, addr_d;
   logic [NREQ-1:0] win_oh;
   logic [IW-1:0]   win_idx;
   logic            win_any;
   logic            issue, resp;
`ifndef CNT_ARB_FIXED_PRIO_EN
   logic [IW-1:0]   ptr_q, ptr_d;
`endif

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i    (bus.req),
`ifndef CNT_ARB_FIXED_PRIO_EN
      .ptr_i    (ptr_q),
`endif
      .onehot_o (win_oh),
      .idx_o    (win_idx),
      .any_o    (win_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         cmd_q   <= CMD_LOAD;
         data_q  <= '0;
         addr_q  <= '0;
`ifndef CNT_ARB_FIXED_PRIO_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
`ifndef CNT_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      addr_d  = addr_q;
`ifndef CNT_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: if (win_any) begin
            state_d = ISSUE;
            id_d    = win_idx;
            cmd_d   = bus.req_cmd[win_idx];
            data_d  = bus.req_data[win_idx*DW +: DW];
            addr_d  = bus.req_addr[win_idx*DW +: DW];
`ifndef CNT_ARB_FIXED_PRIO_EN
            ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
         end
         ISSUE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are gated by rst so a reset landing in ISSUE/RESP abandons the op immediately.
   assign issue         = (state_q == ISSUE) && !rst;
   assign resp          = (state_q == RESP) && !rst;
   assign bus.gnt       = ((state_q == IDLE) && !rst) ? win_oh : '0;
   // Outside ISSUE the counter reloads its own value so it holds.
   assign bus.cmd       = issue ? cmd_q : CMD_LOAD;
   assign bus.data      = issue ? data_q : bus.dout;
   assign bus.addr      = issue ? addr_q : '0;
   assign bus.rsp_valid = resp;
   assign bus.rsp_id    = resp ? id_q : '0;
   assign bus.rsp_data  = resp ? bus.dout : '0;
endmodule

// File: tb/tb_cnt_arbiter.sv
// tb_cnt_arbiter: directed and random checks of cnt_arbiter against a transaction-level model
module tb_cnt_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] cnt = 8'h00;
   int total = 0;
   int bad = 0;
   int p = 0;
   int ref_cnt = 0;

   always #5 clk = ~clk;

   cnt_arbiter_if #(.NREQ(4), .DW(8)) bus ();
   cnt_arbiter #(.NREQ(4), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   // External counter: load when cmd=0, increment when cmd=1.
   always @(posedge clk) cnt <= bus.cmd ? cnt + 8'd1 : bus.data;
   assign bus.dout = cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] m);
      for (int k = 0; k < 4; k++) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
         int i = k;
`else
         int i = (p + k) % 4;
`endif
         if (m[i]) return i;
      end
      return 0;
   endfunction

   // One full grant/issue/response transaction; entered and left just after a rising edge in IDLE.
   task automatic txn(input logic [3:0] m, input logic [3:0] c, input logic [31:0] d, input logic [31:0] a);
      int w;
      int exp;
      bus.req = m; bus.req_cmd = c; bus.req_data = d; bus.req_addr = a;
      w = pick(m);
      exp = c[w] ? (ref_cnt + 1) % 256 : int'(d[w*8 +: 8]);
      @(negedge clk);
      chk("gnt", 32'(bus.gnt), 32'(1) << w);
      chk("hold_data", 32'(bus.data), ref_cnt);
      chk("hold_cmd", 32'(bus.cmd), 0);
      p = (w + 1) % 4;
      @(posedge clk); #1;
      @(negedge clk);
      chk("issue_cmd", 32'(bus.cmd), 32'(c[w]));
      chk("issue_data", 32'(bus.data), 32'(d[w*8 +: 8]));
      chk("issue_addr", 32'(bus.addr), 32'(a[w*8 +: 8]));
      chk("issue_gnt", 32'(bus.gnt), 0);
      chk("issue_rsp", 32'(bus.rsp_valid), 0);
      @(posedge clk); #1;
      ref_cnt = exp;
      @(negedge clk);
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_id", 32'(bus.rsp_id), w);
      chk("rsp_data", 32'(bus.rsp_data), exp);
      chk("resp_gnt", 32'(bus.gnt), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0] m;
      bus.req = '0; bus.req_cmd = '0; bus.req_data = '0; bus.req_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 0);
      chk("rst_cmd", 32'(bus.cmd), 0);
      chk("rst_data", 32'(bus.data), 0);
      chk("rst_addr", 32'(bus.addr), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      // single load by requester 1
      txn(4'b0010, 4'b0000, 32'h005A_0000 | 32'h0000_5A00, 32'h0000_C300);
      chk("load_cnt", 32'(cnt), 32'h5A);
      // idle hold
      txn(4'b0100, 4'b0000, 32'h0033_0000, 32'h0011_0000);
      bus.req = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_dout", 32'(cnt), 32'h33);
         chk("idle_cmd", 32'(bus.cmd), 0);
         chk("idle_data", 32'(bus.data), 32'h33);
         @(posedge clk); #1;
      end
      // fairness: clear counter via requester 3, then all increment
      txn(4'b1000, 4'b0000, 32'h0000_0000, 32'h0000_0000);
      for (int i = 0; i < 5; i++) txn(4'b1111, 4'b1111, 32'h0102_0304, 32'hA0B0_C0D0);
      chk("fair_end", 32'(cnt), 5);
      // wrap-around
      txn(4'b0010, 4'b0000, 32'h0000_FF00, 32'h0);
      txn(4'b0010, 4'b0010, 32'h0000_FF00, 32'h0);
      chk("wrap_cnt", 32'(cnt), 0);
      // reset during ISSUE
      bus.req = 4'b0100; bus.req_cmd = 4'b0000; bus.req_data = 32'h0077_0000;
      m = 4'b0100;
      @(negedge clk);
      chk("rst_op_gnt", 32'(bus.gnt), 32'(1) << pick(m));
      @(posedge clk); #1;
      rst = 1'b1; bus.req = '0;
      @(negedge clk);
      chk("rst_op_cmd", 32'(bus.cmd), 0);
      chk("rst_op_data", 32'(bus.data), ref_cnt);
      chk("rst_op_rsp", 32'(bus.rsp_valid), 0);
      @(posedge clk); #1;
      rst = 1'b0; p = 0;
      @(negedge clk);
      chk("post_rst_rsp", 32'(bus.rsp_valid), 0);
      chk("post_rst_gnt", 32'(bus.gnt), 0);
      chk("post_rst_cnt", 32'(cnt), ref_cnt);
      @(posedge clk); #1;
      txn(4'b1110 | 4'b0001, 4'b1111, 32'h0, 32'h0);
      // fixed-priority scenario (round-robin model applies in the default build)
      for (int i = 0; i < 3; i++) txn(4'b1001, 4'b1001, 32'h0, 32'h0);
      txn(4'b1000, 4'b1000, 32'h0, 32'h0);
      // random traffic
      for (int i = 0; i < 30; i++)
         txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom, $urandom);
      bus.req = '0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
